issue_queue_ctrl: RTL and testbench

// In-order circular issue queue and issue sequencer for one execution class. Accepts up to two

---
 rtl/issue_queue_ctrl_pkg.sv | 17 +
 rtl/issue_queue_ctrl_ring_ptr.sv | 25 ++
 rtl/issue_queue_ctrl.sv | 129 ++++++++++++
 tb/tb_issue_queue_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/issue_queue_ctrl_pkg.sv
// Shared types and sizing for the in-order issue queue and its pointer helper.
package issue_queue_ctrl_pkg;

    localparam int unsigned ISSUE_WAYS = 2;
    localparam int unsigned IQ_DEPTH   = 8;
    localparam int unsigned IQ_PTR_W   = $clog2(IQ_DEPTH);

    typedef logic [IQ_PTR_W-1:0] iq_ptr_t;

    // Decoded instruction payload carried from dispatch to the exec class.
    typedef struct packed {
        logic [7:0]  opcode;
        logic [5:0]  rob_tag;
        logic [15:0] imm;
    } instr_info_t;

endpackage

// File: rtl/issue_queue_ctrl_ring_ptr.sv
// Circular pointer: advances by 0/1/2 per cycle, wraps modulo 2**PTR_W, clears synchronously.
module iq_ring_ptr #(
    parameter int unsigned PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [1:0]       inc,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] r_ptr;

    // Power-of-two depth makes the natural adder overflow the wrap.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= r_ptr + PTR_W'(inc);
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/issue_queue_ctrl.sv
// In-order circular issue queue: dual enqueue from dispatch, in-order 0/1/2 issue into a
// registered issue stage, gated by external wake-up verdicts and exec back-pressure.
module issue_queue_ctrl
    import issue_queue_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = IQ_DEPTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [ISSUE_WAYS-1:0]            enq_valid,
    input  instr_info_t [ISSUE_WAYS-1:0]     enq_instr,
    output logic                             enq_ready,
    output logic [ISSUE_WAYS-1:0]            head_valid,
    output instr_info_t [ISSUE_WAYS-1:0]     head_instr,
    input  logic [ISSUE_WAYS-1:0]            wake_ready,
    input  logic                             exec_stall,
    output logic [ISSUE_WAYS-1:0]            issue_valid,
    output instr_info_t [ISSUE_WAYS-1:0]     issue_instr,
    output logic [$clog2(DEPTH):0]           occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [PTR_W-1:0]            w_head;
    logic [PTR_W-1:0]            w_tail;
    logic [PTR_W-1:0]            w_head_p1;
    logic [PTR_W-1:0]            w_tail_p1;
    logic                        w_enq_fire;
    logic [1:0]                  w_enq_n;
    logic                        w_deq0;
    logic                        w_deq1;
    logic [1:0]                  w_deq_n;
    logic                        w_clr;

    instr_info_t                 r_mem [DEPTH];
    logic [OCC_W-1:0]            r_occ;
    logic [ISSUE_WAYS-1:0]       r_issue_valid;
    instr_info_t [ISSUE_WAYS-1:0] r_issue_instr;

    assign w_clr     = flush;
    assign w_head_p1 = w_head + PTR_W'(1);
    assign w_tail_p1 = w_tail + PTR_W'(1);

    // Enqueue acceptance and issue selection; flush discards both.
    always_comb begin
        enq_ready     = 1'b0;
        w_enq_fire    = 1'b0;
        w_enq_n       = 2'd0;
        head_valid    = '0;
        w_deq0        = 1'b0;
        w_deq1        = 1'b0;
        w_deq_n       = 2'd0;

        enq_ready     = (r_occ <= OCC_W'(DEPTH - 2)) && !flush;
        w_enq_fire    = enq_ready && enq_valid[0];
        if (w_enq_fire) begin
            w_enq_n = enq_valid[1] ? 2'd2 : 2'd1;
        end

        head_valid[0] = (r_occ >= OCC_W'(1));
        head_valid[1] = (r_occ >= OCC_W'(2));
        w_deq0        = head_valid[0] && wake_ready[0] && !exec_stall;
        w_deq1        = w_deq0 && head_valid[1] && wake_ready[1];
        if (!flush) begin
            w_deq_n = {1'b0, w_deq0} + {1'b0, w_deq1};
        end
    end

    assign head_instr[0] = r_mem[w_head];
    assign head_instr[1] = r_mem[w_head_p1];

    iq_ring_ptr #(.PTR_W(PTR_W)) u_head_ptr (
        .clk (clk),
        .rst (rst),
        .clr (w_clr),
        .inc (w_deq_n),
        .ptr (w_head)
    );

    iq_ring_ptr #(.PTR_W(PTR_W)) u_tail_ptr (
        .clk (clk),
        .rst (rst),
        .clr (w_clr),
        .inc (w_enq_n),
        .ptr (w_tail)
    );

    // Storage needs no reset: entries are only observed while counted in occupancy.
    always_ff @(posedge clk) begin
        if (w_enq_fire) begin
            r_mem[w_tail] <= enq_instr[0];
            if (enq_valid[1]) begin
                r_mem[w_tail_p1] <= enq_instr[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + OCC_W'(w_enq_n) - OCC_W'(w_deq_n);
        end
    end

    // Issue stage holds under stall, but a flush still empties it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_valid <= '0;
            r_issue_instr <= '0;
        end else if (flush) begin
            r_issue_valid <= '0;
        end else if (!exec_stall) begin
            r_issue_valid <= {w_deq1, w_deq0};
            r_issue_instr <= head_instr;
        end
    end

    assign issue_valid = r_issue_valid;
    assign issue_instr = r_issue_instr;
    assign occupancy   = r_occ;

    a_enq_legal: assert property (@(posedge clk) disable iff (rst) enq_valid != 2'b10);
    a_occ_bound: assert property (@(posedge clk) disable iff (rst) r_occ <= OCC_W'(DEPTH));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(w_deq0 && r_occ == '0));

endmodule

// File: tb/tb_issue_queue_ctrl.sv
// Randomized bench: a queue-based reference model predicts each cycle's issue stage,
// and a separate monitor pops the predictions and compares them after every clock edge.
module tb_issue_queue_ctrl;
    import issue_queue_ctrl_pkg::*;

    localparam int DEPTH = 8;

    logic                clk;
    logic                rst;
    logic                flush;
    logic [1:0]          enq_valid;
    instr_info_t [1:0]   enq_instr;
    logic                enq_ready;
    logic [1:0]          head_valid;
    instr_info_t [1:0]   head_instr;
    logic [1:0]          wake_ready;
    logic                exec_stall;
    logic [1:0]          issue_valid;
    instr_info_t [1:0]   issue_instr;
    logic [3:0]          occupancy;

    issue_queue_ctrl #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .enq_valid   (enq_valid),
        .enq_instr   (enq_instr),
        .enq_ready   (enq_ready),
        .head_valid  (head_valid),
        .head_instr  (head_instr),
        .wake_ready  (wake_ready),
        .exec_stall  (exec_stall),
        .issue_valid (issue_valid),
        .issue_instr (issue_instr),
        .occupancy   (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  iv;
        instr_info_t i0;
        instr_info_t i1;
        bit          all;
        int          occ;
    } snap_t;

    snap_t       sb[$];
    instr_info_t mq[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          model_init = 0;
    logic [1:0]  exp_iv = '0;
    instr_info_t exp_i0 = '0;
    instr_info_t exp_i1 = '0;
    bit          exp_all = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic instr_info_t rnd_instr();
        return instr_info_t'(30'($urandom()));
    endfunction

    // One clock of stimulus: check combinational view, advance model, post the prediction.
    task automatic cycle(input logic r, input logic f, input logic [1:0] ev,
                         input logic [1:0] wr, input logic st);
        int    sz;
        int    n;
        bit    rdy;
        snap_t s;
        @(negedge clk);
        rst        = r;
        flush      = f;
        enq_valid  = ev;
        wake_ready = wr;
        exec_stall = st;
        enq_instr[0] = rnd_instr();
        enq_instr[1] = rnd_instr();
        #1;
        sz  = mq.size();
        rdy = ((DEPTH - sz) >= 2) && !f;
        if (model_init) begin
            chk("enq_ready", 32'(enq_ready), 32'(rdy));
            chk("head_valid", 32'(head_valid), {30'd0, sz >= 2, sz >= 1});
            if (sz >= 1) chk("head_instr0", 32'(head_instr[0]), 32'(mq[0]));
            if (sz >= 2) chk("head_instr1", 32'(head_instr[1]), 32'(mq[1]));
        end
        if (r) begin
            mq.delete();
            exp_iv  = '0;
            exp_i0  = '0;
            exp_i1  = '0;
            exp_all = 1;
            model_init = 1;
        end else if (f) begin
            mq.delete();
            exp_iv = '0;
        end else begin
            n = 0;
            if (!st && sz >= 1 && wr[0]) n = (sz >= 2 && wr[1]) ? 2 : 1;
            if (!st) begin
                exp_iv  = (n == 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
                exp_all = 0;
                if (n >= 1) exp_i0 = mq[0];
                if (n == 2) exp_i1 = mq[1];
            end
            for (int k = 0; k < n; k++) void'(mq.pop_front());
            if (rdy && ev[0]) begin
                mq.push_back(enq_instr[0]);
                if (ev[1]) mq.push_back(enq_instr[1]);
            end
        end
        s.iv  = exp_iv;
        s.i0  = exp_i0;
        s.i1  = exp_i1;
        s.all = exp_all;
        s.occ = mq.size();
        sb.push_back(s);
    endtask

    // Monitor: one prediction per clock edge, checked just after the edge.
    initial begin
        snap_t s;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                s = sb.pop_front();
                chk("occupancy", 32'(occupancy), 32'(s.occ));
                chk("issue_valid", 32'(issue_valid), 32'(s.iv));
                if (s.all || s.iv[0]) chk("issue_instr0", 32'(issue_instr[0]), 32'(s.i0));
                if (s.all || s.iv[1]) chk("issue_instr1", 32'(issue_instr[1]), 32'(s.i1));
            end
        end
    end

    initial begin
        logic [1:0] ev;
        int         k;
        rst = 1'b1; flush = 1'b0; enq_valid = '0; wake_ready = '0; exec_stall = 1'b0;
        enq_instr = '0;

        repeat (2) cycle(1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        // Fill to full with no wake-ups; enq_ready drops once occupancy reaches 7.
        repeat (5) cycle(1'b0, 1'b0, 2'b11, 2'b00, 1'b0);
        // In-order blocking: way1 ready alone must not issue.
        cycle(1'b0, 1'b0, 2'b00, 2'b10, 1'b0);
        cycle(1'b0, 1'b0, 2'b00, 2'b01, 1'b0);
        // Dual issue from a fresh {A,B,C}.
        cycle(1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
        cycle(1'b0, 1'b0, 2'b11, 2'b00, 1'b0);
        cycle(1'b0, 1'b0, 2'b01, 2'b00, 1'b0);
        cycle(1'b0, 1'b0, 2'b00, 2'b11, 1'b0);
        // Stall holds the issue stage, then flush with a concurrent enqueue.
        cycle(1'b0, 1'b0, 2'b11, 2'b11, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 2'b00, 2'b11, 1'b1);
        cycle(1'b0, 1'b1, 2'b11, 2'b11, 1'b1);
        // Wrap with concurrent enqueue/dequeue at low occupancy.
        repeat (7) cycle(1'b0, 1'b0, 2'b01, 2'b01, 1'b0);
        cycle(1'b0, 1'b0, 2'b11, 2'b01, 1'b0);
        cycle(1'b0, 1'b0, 2'b11, 2'b11, 1'b0);

        for (int c = 0; c < 3000; c++) begin
            k  = $urandom_range(3);
            ev = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'b11;
            cycle(($urandom_range(499) == 0), ($urandom_range(39) == 0), ev,
                  2'($urandom()), ($urandom_range(4) == 0));
        end

        @(negedge clk);
        enq_valid = '0; flush = 1'b0; rst = 1'b0;
        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
